// File: rtl/fx2_packet_tx.sv
// fx2_packet_tx: burst-reads one packet from the channel FIFO and writes it to the FX2 slave FIFO, then idles for a gap
module fx2_packet_tx #(
   parameter int PACKET_WORDS = 256,
   parameter int GAP_CYCLES   = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bus_reset,
   input  logic                 enable,
   input  logic                 packet_rdy,
   input  logic [15:0]          fifo_dout,
   output logic                 rd_req,
   input  logic                 fx2_full,
   output logic [15:0]          fx2_data,
   output logic                 fx2_wr,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic                 overrun,
   input  logic                 clear_status
);
   localparam int CW = $clog2(PACKET_WORDS + GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic rd_d, done;
   assign rd_req = state == READ;
   assign busy = state != IDLE;
   // next state and shared phase counter: words in READ, pipeline flush in DRAIN, idle cycles in GAP
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt + CW'(1);
      done = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (enable && packet_rdy && !fx2_full) state_nxt = READ;
         end
         READ: if (cnt == CW'(PACKET_WORDS - 1)) begin
            state_nxt = DRAIN;
            cnt_nxt = '0;
         end
         DRAIN: if (cnt == CW'(1)) begin
            state_nxt = GAP;
            cnt_nxt = '0;
            done = 1'b1;
         end
         GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
            state_nxt = IDLE;
            cnt_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // state register; either reset abandons the packet in progress
   always_ff @(posedge clk) begin
      if (reset || bus_reset) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
      end
   end
   // two-stage datapath: request, FIFO read latency, then registered word onto the FX2 bus
   always_ff @(posedge clk) begin
      if (reset || bus_reset) begin
         rd_d <= 1'b0;
         fx2_wr <= 1'b0;
         fx2_data <= '0;
      end else begin
         rd_d <= rd_req;
         fx2_wr <= rd_d;
         if (rd_d) fx2_data <= fifo_dout;
      end
   end
   // status: completed-packet counter and sticky overrun (a new overrun beats clear_status)
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count <= '0;
         overrun <= 1'b0;
      end else begin
         if (done && !bus_reset) pkt_count <= pkt_count + CNT_WIDTH'(1);
         if (fx2_wr && fx2_full) overrun <= 1'b1;
         else if (clear_status) overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fx2_packet_tx.sv
// tb_fx2_packet_tx: randomized and directed bench for fx2_packet_tx with a packet-position reference model
module tb_fx2_packet_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b1, bus_reset = 1'b0, enable = 1'b0, packet_rdy = 1'b0, fx2_full = 1'b0, clear_status = 1'b0;
   int total = 0, bad = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar i = 0; i < 2; i++) begin : g
      localparam int N = i ? 4 : 256;
      localparam int G = 4;
      localparam int CW = i ? 4 : 16;
      logic [15:0] fifo_dout = '0, fcnt = '0, fx2_data;
      logic rd_req, fx2_wr, busy, overrun;
      logic [CW-1:0] pkt_count;
      fx2_packet_tx #(.PACKET_WORDS(N), .GAP_CYCLES(G), .CNT_WIDTH(CW)) dut (
         .clk(clk), .reset(reset), .bus_reset(bus_reset), .enable(enable), .packet_rdy(packet_rdy),
         .fifo_dout(fifo_dout), .rd_req(rd_req), .fx2_full(fx2_full), .fx2_data(fx2_data),
         .fx2_wr(fx2_wr), .busy(busy), .pkt_count(pkt_count), .overrun(overrun), .clear_status(clear_status));
      // FIFO stand-in: returns a running word index one cycle after each request
      always @(posedge clk) if (rd_req) begin
         fifo_dout <= fcnt;
         fcnt <= fcnt + 16'd1;
      end
      int p = -1, rd_cnt = 0, start_rd = 0, cnt = 0;
      int rises = 0, last_rise = 0, gap = 0, wrs = 0, rds = 0;
      bit ovr = 0, e_rd = 0, e_wr = 0, e_busy = 0, wr_now, prev_rd = 0;
      logic [15:0] edata = '0;
      // model: p is the cycle index within the current packet (-1 when idle); plus DUT activity monitors
      always @(posedge clk) begin
         wr_now = p >= 2 && p <= N + 1;
         if (p >= 0 && p < N) rd_cnt++;
         if (wr_now && fx2_full) ovr = 1;
         else if (clear_status) ovr = 0;
         if (reset || bus_reset) begin
            p = -1;
            edata = '0;
            if (reset) begin
               cnt = 0;
               ovr = 0;
            end
         end else if (p < 0) begin
            if (enable && packet_rdy && !fx2_full) begin
               p = 0;
               start_rd = rd_cnt;
            end
         end else begin
            if (p == N + 1) cnt = (cnt + 1) % (1 << CW);
            p++;
            if (p == N + 2 + G) p = -1;
         end
         e_rd = p >= 0 && p < N;
         e_wr = p >= 2 && p <= N + 1;
         e_busy = p >= 0;
         if (e_wr) edata = 16'(start_rd + p - 2);
         if (rd_req && !prev_rd) begin
            gap = int'($time / 10) - last_rise;
            last_rise = int'($time / 10);
            rises++;
         end
         prev_rd = rd_req;
         if (fx2_wr) wrs++;
         if (rd_req) rds++;
      end
   end

   // per-cycle comparison of both instances against the model
   always @(negedge clk) if (chk_on) begin
      chk("rd0", g[0].rd_req, g[0].e_rd);
      chk("wr0", g[0].fx2_wr, g[0].e_wr);
      chk("busy0", g[0].busy, g[0].e_busy);
      chk("data0", g[0].fx2_data, g[0].edata);
      chk("cnt0", g[0].pkt_count, g[0].cnt);
      chk("ovr0", g[0].overrun, g[0].ovr);
      chk("rd1", g[1].rd_req, g[1].e_rd);
      chk("wr1", g[1].fx2_wr, g[1].e_wr);
      chk("busy1", g[1].busy, g[1].e_busy);
      chk("data1", g[1].fx2_data, g[1].edata);
      chk("cnt1", g[1].pkt_count, g[1].cnt);
      chk("ovr1", g[1].overrun, g[1].ovr);
   end

   function automatic int mon(input int w);
      return w == 0 ? g[0].rises : w == 1 ? g[0].wrs : w == 2 ? g[0].rds : g[1].rises;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(input logic v, input int lim, input string nm);
      int k = 0;
      while (g[0].busy !== v && k < lim) begin
         step();
         k++;
      end
      chk(nm, g[0].busy, v);
   endtask

   task automatic wait_mon(input int w, input int target, input int lim, input string nm);
      int k = 0;
      while (mon(w) < target && k < lim) begin
         step();
         k++;
      end
      chk(nm, mon(w), target);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_rd"}, g[0].rd_req, 0);
      chk({nm, "_wr"}, g[0].fx2_wr, 0);
      chk({nm, "_data"}, g[0].fx2_data, 0);
      chk({nm, "_busy"}, g[0].busy, 0);
      chk({nm, "_cnt"}, g[0].pkt_count, 0);
      chk({nm, "_ovr"}, g[0].overrun, 0);
   endtask

   initial begin
      int r0, w0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_on = 1'b1;
      chk_reset_vals("rst");
      // single packet
      w0 = g[0].wrs;
      enable = 1'b1;
      packet_rdy = 1'b1;
      wait_busy(1'b1, 5, "start1");
      enable = 1'b0;
      wait_busy(1'b0, 400, "end1");
      chk("p1_words", g[0].wrs - w0, 256);
      chk("p1_last", g[0].fx2_data, 16'd255);
      chk("p1_cnt", g[0].pkt_count, 1);
      chk("p1_ovr", g[0].overrun, 0);
      // endpoint full gating, then three back-to-back packets
      r0 = g[0].rises;
      fx2_full = 1'b1;
      enable = 1'b1;
      repeat (100) step();
      chk("gate_norise", g[0].rises - r0, 0);
      chk("gate_idle", g[0].rd_req, 0);
      fx2_full = 1'b0;
      step();
      chk("gate_start", g[0].rd_req, 1);
      wait_mon(0, r0 + 2, 600, "b2b_rise2");
      chk("b2b_gap1", g[0].gap, 263);
      wait_mon(0, r0 + 3, 600, "b2b_rise3");
      chk("b2b_gap2", g[0].gap, 263);
      enable = 1'b0;
      wait_busy(1'b0, 400, "b2b_end");
      chk("b2b_cnt", g[0].pkt_count, 4);
      // one-cycle fx2_full pulse at word 100
      w0 = g[0].wrs;
      enable = 1'b1;
      wait_busy(1'b1, 5, "mf_start");
      enable = 1'b0;
      wait_mon(1, w0 + 100, 400, "mf_w100");
      fx2_full = 1'b1;
      step();
      fx2_full = 1'b0;
      wait_busy(1'b0, 400, "mf_end");
      chk("mf_words", g[0].wrs - w0, 256);
      chk("mf_ovr", g[0].overrun, 1);
      chk("mf_cnt", g[0].pkt_count, 5);
      // bus_reset at word 50 keeps status
      enable = 1'b1;
      wait_busy(1'b1, 5, "br_start");
      enable = 1'b0;
      r0 = g[0].rds;
      wait_mon(2, r0 + 50, 400, "br_w50");
      bus_reset = 1'b1;
      step();
      bus_reset = 1'b0;
      chk("br_rd", g[0].rd_req, 0);
      chk("br_wr", g[0].fx2_wr, 0);
      chk("br_busy", g[0].busy, 0);
      chk("br_cnt", g[0].pkt_count, 5);
      chk("br_ovr", g[0].overrun, 1);
      w0 = g[0].wrs;
      enable = 1'b1;
      wait_busy(1'b1, 5, "br_restart");
      enable = 1'b0;
      wait_busy(1'b0, 400, "br_end");
      chk("br_words", g[0].wrs - w0, 256);
      chk("br_cnt2", g[0].pkt_count, 6);
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      chk("clr_ovr", g[0].overrun, 0);
      chk("clr_cnt", g[0].pkt_count, 6);
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         step();
         enable = $urandom_range(0, 3) != 0;
         packet_rdy = $urandom_range(0, 4) != 0;
         fx2_full = $urandom_range(0, 9) == 0;
         clear_status = $urandom_range(0, 19) == 0;
         bus_reset = $urandom_range(0, 299) == 0;
      end
      step();
      {enable, fx2_full, clear_status, bus_reset} = '0;
      packet_rdy = 1'b1;
      // counter wrap on the small instance, then reset in the middle of READ
      reset = 1'b1;
      step();
      reset = 1'b0;
      r0 = g[1].rises;
      enable = 1'b1;
      wait_mon(3, r0 + 17, 400, "wrap_rises");
      enable = 1'b0;
      repeat (30) step();
      chk("wrap_cnt", g[1].pkt_count, 1);
      chk("mid_read", g[0].rd_req, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset_vals("midrst");
      repeat (5) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
